ysyx_24100029_fencei_seq: RTL and testbench
===========================================

YSYX_24100029_FENCEI_SEQ -- requirements
Module: ysyx_24100029_fencei_seq

Interface
REQ-001 SHALL have parameter DRAIN_CYC, default 2, minimum cycles spent in DRAIN; legal range 1..15.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fence_i_flag  input  1  the instruction in EXU is fence.i.
REQ-005 SHALL have port EXU_valid  input  1  EXU holds a valid instruction.
REQ-006 SHALL have port LSU_ready  input  1  LSU can accept the EXU instruction this cycle.
REQ-007 SHALL have port EXU_pc  input  32  PC of the EXU instruction.
REQ-008 SHALL have port mem_idle  input  1  LSU/WBU hold no outstanding access.
REQ-009 SHALL have port icache_inv_ack  input  1  icache invalidate complete.
REQ-010 SHALL have port icache_inv_req  output  1  icache invalidate request.
REQ-011 SHALL have port pipe_clear  output  1  flush IDU/EXU younger instructions.
REQ-012 SHALL have port fetch_hold  output  1  IFU must not issue fetches.
REQ-013 SHALL have port busy  output  1  sequence in progress.
REQ-014 SHALL have port dnpc_flag  output  1  one-cycle fetch redirect strobe.
REQ-015 SHALL have port dnpc  output  32  redirect target.

Function
REQ-016 SHALL implement FSM states IDLE, DRAIN, INV, REDIRECT.
REQ-017 Accept: in IDLE, accept = fence_i_flag & EXU_valid & LSU_ready; on accept, latch ret_pc = EXU_pc + 4 mod 2^32, clear the drain counter, go to DRAIN.
REQ-018 pipe_clear SHALL be combinational and equal accept; it is high only in the accept cycle.
REQ-019 DRAIN: the 4-bit counter increments each cycle and saturates at 15; exit to INV when counter >= DRAIN_CYC-1 and mem_idle=1; otherwise stay.
REQ-020 INV: icache_inv_req=1 (Moore); transfer occurs when icache_inv_req & icache_inv_ack; then go to REDIRECT; the request stays high until the transfer occurs.
REQ-021 icache_inv_ack SHALL be ignored in every state except INV.
REQ-022 REDIRECT: dnpc_flag=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-023 dnpc SHALL equal ret_pc at all times, and SHALL change only on accept.
REQ-024 busy = fetch_hold = (state != IDLE).
REQ-025 fence_i_flag SHALL be ignored outside IDLE, so no nested sequence is possible.
REQ-026 Latency: with mem_idle=1 and immediate ack, for accept at cycle T the block SHALL enter INV at T+1+DRAIN_CYC, pulse dnpc_flag at T+2+DRAIN_CYC, and be back in IDLE at T+3+DRAIN_CYC.
REQ-027 While mem_idle=0 the block SHALL stay in DRAIN indefinitely; there is no timeout.

Reset
REQ-028 reset SHALL put state to IDLE, counter to 0, and ret_pc to 0x00000000 on the next rising edge, taking priority over all transitions.
REQ-029 After reset, icache_inv_req, dnpc_flag, busy and fetch_hold SHALL be 0, and dnpc SHALL be 0.
REQ-030 Reset asserted in DRAIN, INV or REDIRECT SHALL abort the sequence: no dnpc_flag pulse, and icache_inv_req low from the following cycle.
REQ-031 pipe_clear SHALL be forced to 0 in any cycle where reset=1.

Configuration
REQ-032 Macro YSYX_24100029_FENCEI_CNT_EN, when defined, SHALL add output fencei_cnt (32 bits), cleared by reset and incremented once per REDIRECT cycle, wrapping 0xFFFFFFFF->0.
REQ-033 When YSYX_24100029_FENCEI_CNT_EN is undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Basic: DRAIN_CYC=2, EXU_pc=0x80000010, accept at T, mem_idle=1, ack held 1 -> pipe_clear at T, icache_inv_req at T+3, dnpc_flag at T+4 with dnpc=0x80000014, busy low at T+5.
REQ-035 Drain stall: mem_idle=0 for 6 cycles after accept -> state stays DRAIN and icache_inv_req stays 0; INV is entered the cycle after mem_idle rises.
REQ-036 Slow ack: ack arrives 5 cycles after INV is entered -> icache_inv_req stays high all 6 cycles, and dnpc_flag follows the transfer cycle by 1.
REQ-037 Wrap and gating: EXU_pc=0xFFFFFFFC -> dnpc=0x00000000; fence_i_flag=1 with LSU_ready=0 -> no accept; stray ack in IDLE -> no effect.
REQ-038 Reset mid-INV: assert reset while in INV -> IDLE next cycle, no dnpc_flag, icache_inv_req=0, dnpc=0.
REQ-039 With YSYX_24100029_FENCEI_CNT_EN defined, three complete sequences -> fencei_cnt=3; reset -> fencei_cnt=0.

Source files
------------

// File: rtl/ysyx_24100029_fencei_seq_if.sv
//==============================================================================
// Module      : ysyx_24100029_fencei_seq_if
// Description : Pipeline-side handshake bundle for the fence.i sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ysyx_24100029_fencei_seq_if;
    logic        fence_i_flag;
    logic        EXU_valid;
    logic        LSU_ready;
    logic [31:0] EXU_pc;
    logic        mem_idle;
    logic        icache_inv_ack;
    logic        icache_inv_req;
    logic        pipe_clear;
    logic        fetch_hold;
    logic        busy;
    logic        dnpc_flag;
    logic [31:0] dnpc;

    // The sequencer itself
    modport slave (
        input  fence_i_flag, EXU_valid, LSU_ready, EXU_pc, mem_idle, icache_inv_ack,
        output icache_inv_req, pipe_clear, fetch_hold, busy, dnpc_flag, dnpc
    );

    // The surrounding pipeline / icache
    modport master (
        output fence_i_flag, EXU_valid, LSU_ready, EXU_pc, mem_idle, icache_inv_ack,
        input  icache_inv_req, pipe_clear, fetch_hold, busy, dnpc_flag, dnpc
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_24100029_fencei_seq.sv
//==============================================================================
// Module      : ysyx_24100029_fencei_seq
// Description : fence.i sequencer: drain memory, invalidate icache, redirect
//               fetch to pc+4. Optional macro YSYX_24100029_FENCEI_CNT_EN adds
//               a 32-bit completed-sequence counter output (fencei_cnt).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ysyx_24100029_fencei_seq #(
    parameter int DRAIN_CYC = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    ysyx_24100029_fencei_seq_if.slave    bus
`ifdef YSYX_24100029_FENCEI_CNT_EN
    ,
    output logic [31:0]                  fencei_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_INV      = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [3:0] C_DRAIN_LAST = 4'(DRAIN_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_drain_cnt;
    logic [31:0] r_ret_pc;
    logic        w_accept;

    assign w_accept = (r_state == S_IDLE) & bus.fence_i_flag & bus.EXU_valid & bus.LSU_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 4'd0;
            r_ret_pc    <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ret_pc    <= bus.EXU_pc + 32'd4;
                r_drain_cnt <= 4'd0;
            end else if ((r_state == S_DRAIN) && (r_drain_cnt != 4'hF)) begin
                r_drain_cnt <= r_drain_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Minimum dwell is guaranteed by the counter; memory must also be quiet
                if ((r_drain_cnt >= C_DRAIN_LAST) && bus.mem_idle) w_state_nxt = S_INV;
            end
            S_INV: begin
                if (bus.icache_inv_ack) w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.pipe_clear     = w_accept & ~reset;
    assign bus.icache_inv_req = (r_state == S_INV);
    assign bus.dnpc_flag      = (r_state == S_REDIRECT);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.fetch_hold     = (r_state != S_IDLE);
    assign bus.dnpc           = r_ret_pc;

`ifdef YSYX_24100029_FENCEI_CNT_EN
    logic [31:0] r_fencei_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fencei_cnt <= 32'd0;
        end else if (r_state == S_REDIRECT) begin
            r_fencei_cnt <= r_fencei_cnt + 32'd1;
        end
    end

    assign fencei_cnt = r_fencei_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100029_fencei_seq.sv
//==============================================================================
// Module      : tb_ysyx_24100029_fencei_seq
// Description : Self-checking bench for the fence.i sequencer (DRAIN_CYC=2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ysyx_24100029_fencei_seq;

    localparam int C_DRAIN_CYC = 2;
    localparam int C_BUDGET    = 40;

    typedef struct {
        logic [31:0] pc;
        int          stall;
        int          ack_dly;
        logic [31:0] exp_dnpc;
        int          exp_lat;
    } vec_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q[$];

    ysyx_24100029_fencei_seq_if bus();

`ifdef YSYX_24100029_FENCEI_CNT_EN
    logic [31:0] fencei_cnt;
`endif

    ysyx_24100029_fencei_seq #(
        .DRAIN_CYC (C_DRAIN_CYC)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus)
`ifdef YSYX_24100029_FENCEI_CNT_EN
        ,
        .fencei_cnt (fencei_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept one fence.i, then play memory stall and icache ack timing from the vector
    task automatic run_seq(input vec_t v);
        int          inv_cnt;
        bit          done;
        logic [31:0] got;
        inv_cnt = 0;
        done    = 1'b0;
        @(negedge clock);
        bus.fence_i_flag   = 1'b1;
        bus.EXU_valid      = 1'b1;
        bus.LSU_ready      = 1'b1;
        bus.EXU_pc         = v.pc;
        bus.mem_idle       = (v.stall == 0);
        bus.icache_inv_ack = 1'b0;
        #1;
        check("pipe_clear_on_accept", 32'(bus.pipe_clear), 32'd1);
        exp_q.push_back(v.exp_dnpc);
        for (int c = 1; c <= C_BUDGET && !done; c++) begin
            @(negedge clock);
            bus.EXU_pc   = v.pc ^ 32'h0000_0F00;
            bus.mem_idle = (c > v.stall);
            #1;
            check("no_nested_accept", 32'(bus.pipe_clear), 32'd0);
            check("busy_in_seq", 32'(bus.busy), 32'd1);
            if (c == 1) check("dnpc_after_accept", bus.dnpc, v.exp_dnpc);
            if (c <= v.stall) check("inv_req_during_stall", 32'(bus.icache_inv_req), 32'd0);
            bus.icache_inv_ack = bus.icache_inv_req && (inv_cnt == v.ack_dly);
            if (bus.icache_inv_req) inv_cnt++;
            if (bus.dnpc_flag) begin
                done = 1'b1;
                check("redirect_latency", 32'(c), 32'(v.exp_lat));
                check("inv_req_cycles", 32'(inv_cnt), 32'(v.ack_dly + 1));
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got dnpc 0x%08h expected no redirect", bus.dnpc);
                end else begin
                    got = exp_q.pop_front();
                    check("scoreboard_dnpc", bus.dnpc, got);
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL redirect_timeout: got no dnpc_flag expected one within %0d cycles", C_BUDGET);
        end
        @(negedge clock);
        bus.fence_i_flag   = 1'b0;
        bus.icache_inv_ack = 1'b0;
        bus.mem_idle       = 1'b1;
        #1;
        check("busy_after_seq", 32'(bus.busy), 32'd0);
        check("fetch_hold_after_seq", 32'(bus.fetch_hold), 32'd0);
        check("dnpc_flag_one_cycle", 32'(bus.dnpc_flag), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        bit seen;
        n_checks = 0;
        n_fail   = 0;
        //             pc             stall ack  exp_dnpc        latency
        vecs[0] = '{32'h8000_0010, 0, 0, 32'h8000_0014, 4};
        vecs[1] = '{32'h8000_0100, 6, 0, 32'h8000_0104, 9};
        vecs[2] = '{32'h0000_1000, 0, 5, 32'h0000_1004, 9};
        vecs[3] = '{32'hFFFF_FFFC, 0, 0, 32'h0000_0000, 4};
        vecs[4] = '{32'h1234_5678, 3, 2, 32'h1234_567C, 8};

        reset              = 1'b1;
        bus.fence_i_flag   = 1'b0;
        bus.EXU_valid      = 1'b0;
        bus.LSU_ready      = 1'b0;
        bus.EXU_pc         = 32'h0;
        bus.mem_idle       = 1'b1;
        bus.icache_inv_ack = 1'b0;
        repeat (2) @(posedge clock);

        // Reset state, and pipe_clear masked while reset is high
        @(negedge clock);
        bus.fence_i_flag = 1'b1;
        bus.EXU_valid    = 1'b1;
        bus.LSU_ready    = 1'b1;
        bus.EXU_pc       = 32'hDEAD_BEE0;
        #1;
        check("pipe_clear_in_reset", 32'(bus.pipe_clear), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_fetch_hold", 32'(bus.fetch_hold), 32'd0);
        check("reset_inv_req", 32'(bus.icache_inv_req), 32'd0);
        check("reset_dnpc_flag", 32'(bus.dnpc_flag), 32'd0);
        check("reset_dnpc", bus.dnpc, 32'h0);
`ifdef YSYX_24100029_FENCEI_CNT_EN
        check("reset_fencei_cnt", fencei_cnt, 32'd0);
`endif
        bus.fence_i_flag = 1'b0;
        reset            = 1'b0;

        // Gating: LSU not ready, plus a stray ack in IDLE
        @(negedge clock);
        bus.fence_i_flag   = 1'b1;
        bus.LSU_ready      = 1'b0;
        bus.icache_inv_ack = 1'b1;
        #1;
        check("no_accept_lsu_busy", 32'(bus.pipe_clear), 32'd0);
        @(negedge clock);
        #1;
        check("idle_after_lsu_busy", 32'(bus.busy), 32'd0);
        check("stray_ack_inv_req", 32'(bus.icache_inv_req), 32'd0);
        check("stray_ack_dnpc_flag", 32'(bus.dnpc_flag), 32'd0);
        bus.LSU_ready = 1'b1;
        bus.EXU_valid = 1'b0;
        #1;
        check("no_accept_invalid", 32'(bus.pipe_clear), 32'd0);
        @(negedge clock);
        #1;
        check("idle_after_invalid", 32'(bus.busy), 32'd0);
        check("dnpc_unchanged", bus.dnpc, 32'h0);
        bus.fence_i_flag   = 1'b0;
        bus.icache_inv_ack = 1'b0;

        for (int i = 0; i < 5; i++) run_seq(vecs[i]);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef YSYX_24100029_FENCEI_CNT_EN
        check("fencei_cnt_total", fencei_cnt, 32'd5);
`endif

        // Reset asserted while the icache invalidate is pending
        @(negedge clock);
        bus.fence_i_flag   = 1'b1;
        bus.EXU_valid      = 1'b1;
        bus.LSU_ready      = 1'b1;
        bus.EXU_pc         = 32'h5555_5550;
        bus.mem_idle       = 1'b1;
        bus.icache_inv_ack = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            bus.fence_i_flag = 1'b0;
            #1;
            seen = bus.icache_inv_req;
        end
        check("reached_inv", 32'(seen), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_inv_req", 32'(bus.icache_inv_req), 32'd0);
        check("abort_dnpc_flag", 32'(bus.dnpc_flag), 32'd0);
        check("abort_dnpc", bus.dnpc, 32'h0);
`ifdef YSYX_24100029_FENCEI_CNT_EN
        check("abort_fencei_cnt", fencei_cnt, 32'd0);
`endif
        reset              = 1'b0;
        bus.icache_inv_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            check("post_abort_no_redirect", 32'(bus.dnpc_flag), 32'd0);
            check("post_abort_idle", 32'(bus.busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
